// File: rtl/button_conditioner.sv
// Four-channel push-button front end: two-flop synchroniser, per-channel debounce,
// and single-cycle press pulses with simultaneous-press rejection.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnTopRaw,
    input  logic       btnDownRaw,
    input  logic       btnLeftRaw,
    input  logic       btnRightRaw,
    output logic       buttonTop,
    output logic       buttonDown,
    output logic       buttonLeft,
    output logic       buttonRight,
    output logic [3:0] buttonLevel,
    output logic       multiPress
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw;
    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       db;
    logic [3:0]       db_d;
    logic [3:0]       rise;
    logic [3:0]       pulse;
    logic [CNT_W-1:0] cnt [4];
    logic             single;
    logic             multi;

    assign raw = {btnTopRaw, btnDownRaw, btnLeftRaw, btnRightRaw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Any cycle where s2 matches db restarts qualification, so short bounces never get through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise   = db & ~db_d;
        single = 1'b0;
        multi  = 1'b0;
        if (rise != 4'd0) begin
            single = ((rise & (rise - 4'd1)) == 4'd0);
            multi  = ~single;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_d       <= '0;
            pulse      <= '0;
            multiPress <= 1'b0;
        end else begin
            db_d       <= db;
            pulse      <= single ? rise : 4'd0;
            multiPress <= multi;
        end
    end

    assign buttonTop   = pulse[3];
    assign buttonDown  = pulse[2];
    assign buttonLeft  = pulse[1];
    assign buttonRight = pulse[0];
    assign buttonLevel = db;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for the four push-buttons feeding the code-lock detector. It synchronises each raw asynchronous button input into the clock domain and debounces it. It then emits one clean, single-cycle press pulse per physical press on `buttonTop`/`buttonDown`/`buttonLeft`/`buttonRight`, which the detector consumes directly. Simultaneous presses are rejected and flagged rather than forwarded.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 20: number of consecutive cycles a synchronised level must differ from the debounced level before it is accepted. Legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, default 5: width of each per-channel debounce counter.

Ports:
- `clk`  input  1: single clock; all state is on its rising edge.
- `reset`  input  1: asynchronous, active-high reset; clears all state immediately.
- `btnTopRaw`, `btnDownRaw`, `btnLeftRaw`, `btnRightRaw`  input  1 each: raw, asynchronous, bouncing button levels (1 = pressed).
- `buttonTop`, `buttonDown`, `buttonLeft`, `buttonRight`  output  1 each: registered one-cycle press pulses.
- `buttonLevel`  output  4: debounced levels {Top, Down, Left, Right} = bits [3:0].
- `multiPress`  output  1: registered one-cycle pulse when two or more channels are accepted as pressed in the same cycle.

## Operation

Each of the four channels is independent up to the press-qualification stage.

Synchroniser:
- Two flip-flops, `s1` then `s2`, both reset to 0.
- `s2` is the only version of the raw input used downstream.

Debounce, per channel (`db` level, `cnt` counter, both reset to 0):
- If `s2 == db`: `cnt <= 0`.
- If `s2 != db` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
- If `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`: `db <= s2` and `cnt <= 0`.
- A single-cycle return to `db` restarts qualification from 0. Any bounce shorter than `DEBOUNCE_CYCLES` is fully filtered.
- The counter saturates by construction and never wraps.
- `buttonLevel` = the four `db` bits.

Press qualification:
- `rise[i] = db[i] & ~db_d[i]`, where `db_d` is `db` delayed one cycle (reset 0).
- Exactly one bit of `rise` set: the matching `button*` output pulses next cycle; `multiPress` stays 0.
- Two or more bits of `rise` set: all `button*` outputs stay 0 and `multiPress` pulses next cycle.
- No bits set: all pulse outputs are 0.
- Falling edges of `db` (button releases) produce no pulse.
- A button held indefinitely produces exactly one pulse; there is no auto-repeat.
- Presses accepted on different cycles, even adjacent ones, are each forwarded normally.

Reset:
- Every flop returns to 0 asynchronously, including any in-flight counter, so no pulse is emitted for it.
- A button still held when reset deasserts is treated as a new press: it must requalify and then pulses once.

## Timing

- All outputs are 0 while `reset` is high and on the first cycle after it is released.
- Press latency: let raw be stable high, first sampled into `s1` at edge E. Then:
  - `s2` = 1 after edge E+1.
  - `db` = 1 after edge E+1+`DEBOUNCE_CYCLES`.
  - `button*` = 1 after edge E+2+`DEBOUNCE_CYCLES`, and returns to 0 at the next edge.
- Release latency: `buttonLevel` bit falls after edge E'+1+`DEBOUNCE_CYCLES`, where E' is the first edge sampling raw low.
- At most one of {`buttonTop`, `buttonDown`, `buttonLeft`, `buttonRight`, `multiPress`} is high in any cycle.
- Pulses are exactly one cycle wide, and consecutive pulses on the same channel are at least 2·`DEBOUNCE_CYCLES` cycles apart.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

1. Clean press: `btnTopRaw` rises and is first sampled at edge 10, then held for 60 cycles. Required: `buttonLevel[3]` = 1 after edge 15, `buttonTop` high only in the cycle after edge 16, and no further pulse while the button is held or on release.
2. Bounce: `btnLeftRaw` toggles every 2 cycles for 20 cycles, then stays low. Required: no pulses, and `buttonLevel` remains 0. The sequence then repeats with a final stable high, which must give exactly one `buttonLeft` pulse, 6 edges after the stable level is first sampled.
3. Simultaneous press: `btnLeftRaw` and `btnRightRaw` rise on the same edge. Required: a single `multiPress` pulse, no `buttonLeft`/`buttonRight` pulses, and `buttonLevel` = 4'b0011.
4. Staggered press: `btnRightRaw` rises one cycle after `btnDownRaw`. Required: `buttonDown` pulse, then `buttonRight` pulse on the next cycle, and `multiPress` never asserts.
5. Reset mid-qualification: `btnDownRaw` goes high, and `reset` pulses 3 cycles later while the button is still held. Required: no pulse before or during reset, all outputs 0, then one `buttonDown` pulse 6 edges after the first post-reset sampling edge.
6. Detector sequence: press Top, Left, Left, Right, with each press 10 cycles long and 10-cycle gaps. Required: exactly four pulses in order, matching that sequence, each one cycle wide.
